// File: rtl/cpu_params_pkg.sv
// CPU-wide numeric parameters shared by the pipeline stages.
package cpu_params_pkg;
  localparam int XLEN        = 32;
  localparam int DEC_Q_DEPTH = 2;
endpackage

// File: rtl/cpu_structs_pkg.sv
// Stage-to-stage packet formats for the CPU pipeline.
package cpu_structs_pkg;
  typedef struct packed {
    logic [cpu_params_pkg::XLEN-1:0] pc;
    logic [31:0]                     instr;
  } FET_2_DEC;

  typedef struct packed {
    logic [cpu_params_pkg::XLEN-1:0] pc;
    logic [6:0]                      opcode;
    logic [4:0]                      rd;
    logic [2:0]                      funct3;
    logic [4:0]                      rs1;
    logic [4:0]                      rs2;
    logic [6:0]                      funct7;
    logic [31:0]                     imm;
  } DEC_2_EXE;
endpackage

// File: rtl/dec_qbuf.sv
// Generic power-of-two circular buffer with push/pop/clear and occupancy.
// Read is combinational from the head slot; storage itself is never reset.
module dec_qbuf #(
  parameter type T         = logic [31:0],
  parameter int  DEPTH     = 2,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  T              wr_data_i,
  output T              rd_data_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o
);
  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (pop_i && !push_i) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o    = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
endmodule

// File: rtl/decode_core.sv
// Combinational instruction field decoder: splits the fetched word into
// register/opcode fields and a sign-extended I-type immediate.
module decode_core
  import cpu_structs_pkg::*;
(
  input  FET_2_DEC fet_i,
  output DEC_2_EXE dec_o
);
  always_comb begin
    dec_o        = '0;
    dec_o.pc     = fet_i.pc;
    dec_o.opcode = fet_i.instr[6:0];
    dec_o.rd     = fet_i.instr[11:7];
    dec_o.funct3 = fet_i.instr[14:12];
    dec_o.rs1    = fet_i.instr[19:15];
    dec_o.rs2    = fet_i.instr[24:20];
    dec_o.funct7 = fet_i.instr[31:25];
    dec_o.imm    = {{20{fet_i.instr[31]}}, fet_i.instr[31:20]};
  end
endmodule

// File: rtl/decode_q.sv
// Decode stage with a DEPTH-entry result queue toward Execute. fet_rdy is
// derived from registered occupancy only, so it never depends on dec_rdy.
module decode_q
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter int  DEPTH  = DEC_Q_DEPTH,
  parameter int  AF_LVL = DEPTH - 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          cpu_halt,
  input  logic          pipe_flush,
  input  logic          fet_valid,
  output logic          fet_rdy,
  input  FET_2_DEC      fet_data,
  output logic          dec_valid,
  input  logic          dec_rdy,
  output DEC_2_EXE      dec_data,
  output logic [CW-1:0] occupancy,
  output logic          almost_full
);
  DEC_2_EXE      dec_in;
  DEC_2_EXE      head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          almost_full_q;

  decode_core u_core (
    .fet_i (fet_data),
    .dec_o (dec_in)
  );

  dec_qbuf #(
    .T     (DEC_2_EXE),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i        (clk_in),
    .rst_i        (reset_in),
    .clr_i        (pipe_flush),
    .push_i       (push),
    .pop_i        (pop),
    .wr_data_i    (dec_in),
    .rd_data_o    (head),
    .count_o      (count),
    .count_next_o (count_next)
  );

  // A full queue refuses input even when the head pops this cycle.
  assign fet_rdy   = !reset_in && !cpu_halt && !pipe_flush && (count != CW'(DEPTH));
  assign dec_valid = (count != '0) && !pipe_flush;
  assign push      = fet_valid && fet_rdy;
  assign pop       = dec_valid && dec_rdy;
  assign dec_data  = (count != '0) ? head : '0;
  assign occupancy = count;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) almost_full_q <= 1'b0;
    else          almost_full_q <= (count_next >= CW'(AF_LVL));
  end

  assign almost_full = almost_full_q;
endmodule
